// File: rtl/quotient_otf_converter.sv
// quotient_otf_converter
// Captures a packed radix-4 signed-digit quotient word and converts it to a
// two's-complement binary quotient one digit per cycle with the on-the-fly
// Q/QM register pair. The result is offered on a valid/ready output.
// Optional feature macro: QUOT_REM_CORR_EN -- when defined, rem_neg is latched
// with start and a negative final remainder selects QM (quotient minus one).
//
// Handshake: start is accepted only while in_ready=1 (IDLE); a start at any
// other time is dropped. A result transfers on a clock edge where
// out_valid=1 and out_ready=1; until then quot_out, err and out_valid are held.
module quotient_otf_converter #(
  parameter int NDIGITS = 23,
  localparam int QW = 2 * NDIGITS
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [3*NDIGITS-1:0] digits_in,
  input  logic                 rem_neg,
  output logic                 in_ready,
  output logic [QW-1:0]        quot_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 err,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  localparam int DW = 3 * NDIGITS;
  localparam int CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [DW-1:0]   word_r;
  logic [QW-1:0]   q_r;
  logic [QW-1:0]   qm_r;
  logic [CW-1:0]   cnt;
  logic [2:0]      digit;
  logic [QW-1:0]   q_nxt;
  logic [QW-1:0]   qm_nxt;
  logic [QW-1:0]   quot_sel;
  logic            dig_err;

  assign dbg_state = state;

  // Current digit is always the top field of the shifting captured word.
  assign digit = word_r[DW-1 -: 3];

`ifdef QUOT_REM_CORR_EN
  logic rem_neg_r;
  assign quot_sel = rem_neg_r ? qm_nxt : q_nxt;
`else
  logic unused_rem_neg;
  assign unused_rem_neg = rem_neg;
  assign quot_sel = q_nxt;
`endif

  // On-the-fly append of the current digit to Q (value) and QM (value - 1).
  always_comb begin
    dig_err = 1'b0;
    q_nxt   = {q_r[QW-3:0], 2'b00};
    qm_nxt  = {qm_r[QW-3:0], 2'b11};
    case (digit)
      3'b010: begin  // +2
        q_nxt  = {q_r[QW-3:0], 2'b10};
        qm_nxt = {q_r[QW-3:0], 2'b01};
      end
      3'b001: begin  // +1
        q_nxt  = {q_r[QW-3:0], 2'b01};
        qm_nxt = {q_r[QW-3:0], 2'b00};
      end
      3'b111: begin  // -1
        q_nxt  = {qm_r[QW-3:0], 2'b11};
        qm_nxt = {qm_r[QW-3:0], 2'b10};
      end
      3'b110: begin  // -2
        q_nxt  = {qm_r[QW-3:0], 2'b10};
        qm_nxt = {qm_r[QW-3:0], 2'b01};
      end
      3'b000: ;      // 0: defaults above
      default: dig_err = 1'b1;  // illegal code converts as 0
    endcase
  end

  // Control FSM with registered outputs; the final digit loads quot_out directly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      word_r    <= '0;
      q_r       <= '0;
      qm_r      <= '0;
      cnt       <= '0;
      quot_out  <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
`ifdef QUOT_REM_CORR_EN
      rem_neg_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            word_r   <= digits_in;
            q_r      <= '0;
            qm_r     <= '1;
            cnt      <= '0;
            err      <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
            state    <= CONV;
`ifdef QUOT_REM_CORR_EN
            rem_neg_r <= rem_neg;
`endif
          end
        end
        CONV: begin
          q_r    <= q_nxt;
          qm_r   <= qm_nxt;
          word_r <= word_r << 3;
          cnt    <= cnt + 1'b1;
          err    <= err | dig_err;
          if (cnt == LAST_CNT) begin
            quot_out  <= quot_sel;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quotient_otf_converter.sv
// Bench for quotient_otf_converter at NDIGITS=4 (QW=8): table vectors with
// hand-computed results, random words checked against an arithmetic model,
// plus backpressure and mid-conversion reset sequences.
module tb_quotient_otf_converter;

  localparam int NDIGITS = 4;
  localparam int QW = 2 * NDIGITS;
  localparam int DW = 3 * NDIGITS;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [DW-1:0] digits_in;
  logic          rem_neg;
  logic          in_ready;
  logic [QW-1:0] quot_out;
  logic          out_valid;
  logic          out_ready;
  logic          err;
  logic          busy;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  quotient_otf_converter #(.NDIGITS(NDIGITS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .digits_in (digits_in),
    .rem_neg   (rem_neg),
    .in_ready  (in_ready),
    .quot_out  (quot_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [DW-1:0] digits;
    logic          rn;
    logic [QW-1:0] quot;
    logic          e;
  } vec_t;

  vec_t        vecs[6];
  logic [QW:0] exp_q[$];  // {err, quot}
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed-digit value accumulated arithmetically, mod 2^QW.
  function automatic logic [QW:0] model(input logic [DW-1:0] w, input logic rn);
    int          s;
    int          d;
    logic        e;
    logic [2:0]  c;
    logic [31:0] sv;
    s = 0;
    e = 1'b0;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      c = w[3*i +: 3];
      case (c)
        3'b110:  d = -2;
        3'b111:  d = -1;
        3'b000:  d = 0;
        3'b001:  d = 1;
        3'b010:  d = 2;
        default: begin d = 0; e = 1'b1; end
      endcase
      s = s * 4 + d;
    end
`ifdef QUOT_REM_CORR_EN
    if (rn) s = s - 1;
`else
    if (rn) s = s + 0;
`endif
    sv = s;
    return {e, sv[QW-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [DW-1:0] w, input logic rn);
    @(negedge clk);
    digits_in = w;
    rem_neg   = rn;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    digits_in = '0;
    rem_neg   = 1'b0;
    check("busy_in_conv", busy, 1);
  endtask

  // Wait for the result, compare against the queue head, optionally accept it.
  task automatic collect(input string name, input bit ack, output logic [QW:0] got);
    int lat;
    logic [QW:0] exp;
    lat = 1;
    got = '0;
    @(negedge clk);
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    if (!out_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: out_valid got 0 expected 1", name);
    end else begin
      got = {err, quot_out};
      check({name, "_latency"}, lat, NDIGITS);
      check({name, "_quot"}, quot_out, exp[QW-1:0]);
      check({name, "_err"}, err, exp[QW]);
      check({name, "_busy"}, busy, 0);
      if (ack) begin
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_valid_clr"}, out_valid, 0);
        check({name, "_in_ready"}, in_ready, 1);
        check({name, "_err_clr"}, err, 0);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [QW:0]   got;
    logic [QW:0]   held;
    logic [DW-1:0] w;
    logic          rn;

    vecs[0] = '{12'b001_111_010_000, 1'b0, 8'h38, 1'b0};
`ifdef QUOT_REM_CORR_EN
    vecs[1] = '{12'b001_111_010_000, 1'b1, 8'h37, 1'b0};
`else
    vecs[1] = '{12'b001_111_010_000, 1'b1, 8'h38, 1'b0};
`endif
    vecs[2] = '{12'b000_000_000_111, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{12'b000_000_000_000, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{12'b010_100_001_000, 1'b0, 8'h84, 1'b1};
    vecs[5] = '{12'b001_111_010_000, 1'b0, 8'h38, 1'b0};

    resetn    = 1'b0;
    start     = 1'b0;
    digits_in = '0;
    rem_neg   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_quot", quot_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    resetn = 1'b1;

    // Table vectors
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({vecs[i].e, vecs[i].quot});
      send(vecs[i].digits, vecs[i].rn);
      collect($sformatf("vec%0d", i), 1'b1, got);
    end

    // Random words, including illegal codes
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < NDIGITS; k++) w[3*k +: 3] = 3'($urandom_range(0, 7));
      rn = 1'($urandom_range(0, 1));
      exp_q.push_back(model(w, rn));
      send(w, rn);
      collect($sformatf("rnd%0d", i), 1'b1, got);
    end

    // Backpressure: result held while a new start is pulsed and ignored
    w = 12'b110_001_111_010;
    exp_q.push_back(model(w, 1'b0));
    send(w, 1'b0);
    collect("bp", 1'b0, held);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start     = (k % 2 == 0);
      digits_in = 12'b010_010_010_010;
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_quot", quot_out, held[QW-1:0]);
      check("bp_err", err, held[QW]);
    end
    @(negedge clk);
    start     = 1'b0;
    digits_in = '0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_in_ready_back", in_ready, 1);
    check("bp_valid_clr", out_valid, 0);
    repeat (NDIGITS + 2) @(negedge clk);
    check("bp_ignored_valid", out_valid, 0);
    check("bp_ignored_busy", busy, 0);

    // Reset during the second conversion cycle
    @(negedge clk);
    digits_in = 12'b100_010_010_010;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    digits_in = '0;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_err", err, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_quot", quot_out, 0);
    @(negedge clk);
    resetn = 1'b1;
    w = 12'b000_001_000_111;
    exp_q.push_back(model(w, 1'b0));
    send(w, 1'b0);
    collect("post_abort", 1'b1, got);

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/quotient_otf_converter.md
Name: quotient_otf_converter

Overview:
- Downstream consumer of the radix-4 SRT quotient-digit shift register.
- Captures the packed signed-digit quotient word when the divider signals done, then converts it to a two's-complement binary quotient one digit per cycle using on-the-fly conversion (Q/QM register pair).
- Presents the result on a valid/ready output handshake to the divider's result/writeback stage.

Parameters:
NDIGITS, 23, number of radix-4 quotient digits in the packed input word (3 bits each)
QW, 2*NDIGITS, output quotient width in bits (derived; not to be overridden)

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  capture request; driven by divider done
digits_in  input  3*NDIGITS  packed digits; most significant digit in bits [3*NDIGITS-1 -: 3]
rem_neg  input  1  final partial remainder negative; sampled with start
in_ready  output  1  high when able to accept start
quot_out  output  QW  two's-complement quotient
out_valid  output  1  quot_out and err valid
out_ready  input  1  downstream accepts result
err  output  1  an illegal digit code was seen in this word
busy  output  1  conversion in progress

Behaviour:
- Reset is asynchronous and active-low (resetn): state=IDLE; Q, QM, quot_out, counter and captured word cleared; out_valid=0, err=0, busy=0, in_ready=1.
- Digit encoding (3-bit two's complement): 110=-2, 111=-1, 000=0, 001=+1, 010=+2. Codes 011, 100 and 101 are illegal: treated as 0 and set err (sticky until the result is consumed).
- FSM states: IDLE, CONV, DONE.
  - IDLE: in_ready=1. When start=1, latch digits_in and rem_neg, set Q=0, QM=all ones, counter=0, err=0, and go to CONV. When start=0, stay in IDLE.
  - CONV: busy=1, in_ready=0. Each cycle, take the next digit q, MSB digit first, and update:
    - Q <= (q>=0) ? {Q[QW-3:0], q[1:0]} : {QM[QW-3:0], (4+q)[1:0]}
    - QM <= (q>0) ? {Q[QW-3:0], (q-1)[1:0]} : {QM[QW-3:0], (3+q)[1:0]}
    - After NDIGITS digits have been processed, go to DONE.
  - DONE: out_valid=1. quot_out holds the final quotient (selection defined under Optional Feature). On out_valid & out_ready, go to IDLE next cycle and clear out_valid and err. quot_out holds its value until the next capture.
- Latency: start sampled at rising edge T; out_valid is high from edge T+NDIGITS.
- start while not in IDLE is ignored; no queuing, no error.
- out_ready low holds quot_out, err and out_valid stable indefinitely.
- The ready→IDLE transition and a new start cannot overlap in the same cycle, because in_ready is 0 in DONE.
- resetn low at any point, including mid-CONV, aborts the operation immediately to the reset values above. No partial result is ever presented.
- All arithmetic is modulo 2^QW; no saturation.

Optional Feature:
- Macro: QUOT_REM_CORR_EN.
- Defined: in DONE, quot_out = rem_neg_latched ? QM : Q. This gives the final quotient-minus-one correction when the remainder is negative.
- Undefined: rem_neg is ignored and not latched; quot_out = Q.

Test Plan:
All scenarios use NDIGITS=4 (QW=8).
- Digits {+1,-1,+2,0} = 001_111_010_000, start pulse, rem_neg=0 -> out_valid after 4 cycles, quot_out=8'h38 (56), err=0.
- Same word with rem_neg=1 -> with QUOT_REM_CORR_EN, quot_out=8'h37; without it, quot_out=8'h38.
- Digits {0,0,0,-1} = 000_000_000_111 -> quot_out=8'hFF. Then all zeros -> quot_out=8'h00. Checks QM initialisation and the borrow path.
- Digits {+2,100,+1,0}:
  - expect err=1 and quot_out=8'h84 (the illegal digit is treated as 0);
  - the next clean word returns err=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while pulsing start with a new word.
  - Outputs stay stable, the new start is ignored, and in_ready=0.
  - After out_ready=1, in_ready returns to 1 on the following cycle.
- Drop resetn low at the 2nd CONV cycle -> out_valid, busy and err go to 0 immediately and in_ready=1. A fresh start then produces the correct result with no stale digits.
